// File: rtl/imm_addr_arbiter.sv
// ---------------------------------------------------------------------------
// imm_addr_arbiter
//
// Shares a single 21-to-32 bit sign-extender and 32-bit address adder between
// two requesters:
//   requester 0 : branch/jump target path (PC + offset)
//   requester 1 : load/store effective-address path (register + offset)
//
// The winner of a round-robin arbitration has its base + sext(imm) computed
// and written into a one-entry output register, tagged with its source. The
// output register drains and refills in the same cycle, so a continuously
// ready consumer sees one result per cycle.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req0_valid/ready       handshake for requester 0
//   req0_base, req0_imm    operands for requester 0
//   req1_valid/ready       handshake for requester 1
//   req1_base, req1_imm    operands for requester 1
//   res_valid/ready        handshake for the result consumer
//   res_addr               registered base + sext(imm), wraps modulo 2^DATA_W
//   res_src                0 = result from requester 0, 1 = from requester 1
// ---------------------------------------------------------------------------
module imm_addr_arbiter #(
    parameter int IMM_W  = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_base,
    input  logic [IMM_W-1:0]  req0_imm,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_base,
    input  logic [IMM_W-1:0]  req1_imm,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_addr,
    output logic              res_src
);

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              last_grant;

    logic              slot_free;
    logic              grant0;
    logic              grant1;
    logic              any_grant;
    logic [DATA_W-1:0] sel_base;
    logic [IMM_W-1:0]  sel_imm;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] sum;

    // The slot can accept a new operand pair when it is empty, or when the
    // held result leaves in this same cycle. Reset blocks any acceptance so
    // nothing is handshaken during the reset cycle.
    always_comb begin
        slot_free = 1'b0;
        if (!rst) begin
            slot_free = (state == EMPTY) || res_ready;
        end
    end

    // Round-robin arbitration: a lone requester always wins; under contention
    // the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (slot_free) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign any_grant  = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // One shared sign-extend + add, fed by the granted requester's operands.
    always_comb begin
        sel_base = req0_base;
        sel_imm  = req0_imm;
        if (grant1) begin
            sel_base = req1_base;
            sel_imm  = req1_imm;
        end
    end

    assign sext_imm = {{(DATA_W-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};
    assign sum      = sel_base + sext_imm;

    // Occupancy FSM and output register. A transfer always lands in the slot
    // (whether it was empty or draining). Without a transfer a drain empties
    // the slot but leaves the last address/source visible. The fairness
    // pointer only moves on a transfer, so idle cycles do not bias it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            res_addr   <= '0;
            res_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (any_grant) begin
                state      <= FULL;
                res_addr   <= sum;
                res_src    <= grant1;
                last_grant <= grant1;
            end else if ((state == FULL) && res_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_imm_addr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imm_addr_arbiter
//
// Directed bench for imm_addr_arbiter. The stimulus process pushes the
// hand-computed {src, addr} of every operand pair it expects to be accepted
// into a scoreboard queue; an independent monitor pops and compares each time
// the DUT hands a result to the consumer. Handshake/ready behaviour, reset
// state and hold stability are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_imm_addr_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_base;
    logic [20:0] req0_imm;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_base;
    logic [20:0] req1_imm;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_addr;
    logic        res_src;

    int checks   = 0;
    int failures = 0;

    logic [32:0] expQ[$];

    imm_addr_arbiter #(
        .IMM_W (21),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_base (req0_base),
        .req0_imm  (req0_imm),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_base (req1_base),
        .req1_imm  (req1_imm),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_addr  (res_addr),
        .res_src   (res_src)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive both requesters' operands and valids
    task automatic applyStimulus(input logic v0, input logic [31:0] b0, input logic [20:0] i0,
                                 input logic v1, input logic [31:0] b1, input logic [20:0] i1);
        req0_valid = v0;
        req0_base  = b0;
        req0_imm   = i0;
        req1_valid = v1;
        req1_base  = b1;
        req1_imm   = i1;
    endtask

    // Scoreboard monitor: every consumed result must match the queue head
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result: got src=%0d addr=0x%08h with nothing expected",
                         res_src, res_addr);
            end else begin
                logic [32:0] e;
                e = expQ.pop_front();
                checkOutput("sb_addr", res_addr, e[31:0]);
                checkOutput("sb_src", {31'd0, res_src}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        res_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_1000, 21'h000010, 1'b1, 32'h0, 21'h0);

        // Reset: no readies even with requests present, outputs cleared
        step();
        step();
        @(negedge clk);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_res_addr", res_addr, 32'd0);
        checkOutput("rst_res_src", {31'd0, res_src}, 32'd0);
        checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);

        // Single request on port 0: accepted same cycle, result next cycle
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_1000, 21'h000010, 1'b0, 32'h0, 21'h0);
        expQ.push_back({1'b0, 32'h0000_1010});
        @(negedge clk);
        checkOutput("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        checkOutput("single_req1_ready", {31'd0, req1_ready}, 32'd0);
        checkOutput("single_pre_valid", {31'd0, res_valid}, 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 21'h0);
        @(negedge clk);
        checkOutput("single_latency_valid", {31'd0, res_valid}, 32'd1);

        // Port 1: negative offset, most-negative offset, wrap-around
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h0000_1000, 21'h1FFFFF);
        expQ.push_back({1'b1, 32'h0000_0FFF});
        @(negedge clk);
        checkOutput("neg1_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h0000_0000, 21'h100000);
        expQ.push_back({1'b1, 32'hFFF0_0000});
        @(negedge clk);
        checkOutput("minneg_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'hFFFF_FFF0, 21'h000020);
        expQ.push_back({1'b1, 32'h0000_0010});
        @(negedge clk);
        checkOutput("wrap_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 21'h0);
        step();
        @(negedge clk);
        checkOutput("drain_valid", {31'd0, res_valid}, 32'd0);

        // Contention: last winner was port 1, so grants go 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            step();
            applyStimulus(1'b1, 32'h0000_2000, 21'h000004, 1'b1, 32'h0000_3000, 21'h000008);
            if (i % 2 == 0) expQ.push_back({1'b0, 32'h0000_2004});
            else            expQ.push_back({1'b1, 32'h0000_3008});
            @(negedge clk);
            checkOutput("rr_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_req1_ready", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 21'h0);
        step();
        @(negedge clk);
        checkOutput("rr_drain_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rr_drain_addr_kept", res_addr, 32'h0000_3008);
        checkOutput("rr_drain_src_kept", {31'd0, res_src}, 32'd1);

        // Back-pressure: result held for 3 cycles, requester 1 stalls
        step();
        res_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0100, 21'h1FFFF0, 1'b0, 32'h0, 21'h0);
        expQ.push_back({1'b0, 32'h0000_00F0});
        @(negedge clk);
        checkOutput("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h0000_4000, 21'h000010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("bp_hold_addr", res_addr, 32'h0000_00F0);
            checkOutput("bp_hold_src", {31'd0, res_src}, 32'd0);
            checkOutput("bp_hold_req0_ready", {31'd0, req0_ready}, 32'd0);
            checkOutput("bp_hold_req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
        end
        res_ready = 1'b1;
        expQ.push_back({1'b1, 32'h0000_4010});
        @(negedge clk);
        checkOutput("bp_refill_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 21'h0);
        step();

        // Mid-operation reset with a held result and both requesting
        res_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_0010, 21'h000001, 1'b0, 32'h0, 21'h0);
        @(negedge clk);
        checkOutput("mr_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 21'h000001, 1'b1, 32'h0000_4000, 21'h000010);
        @(negedge clk);
        checkOutput("mr_pre_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("mr_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        checkOutput("mr_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        expQ.push_back({1'b0, 32'h0000_0011});
        @(negedge clk);
        checkOutput("mr_post_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("mr_post_addr", res_addr, 32'd0);
        checkOutput("mr_post_src", {31'd0, res_src}, 32'd0);
        checkOutput("mr_first_req0_ready", {31'd0, req0_ready}, 32'd1);
        checkOutput("mr_first_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        expQ.push_back({1'b1, 32'h0000_4010});
        @(negedge clk);
        checkOutput("mr_second_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 21'h0);

        // Let the scoreboard empty, bounded
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            step();
        end
        step();
        @(negedge clk);
        checkOutput("final_queue_empty", expQ.size(), 32'd0);
        checkOutput("final_valid", {31'd0, res_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_addr_arbiter.md
Name: imm_addr_arbiter

Overview:
- Shares one 21-to-32 sign-extension plus 32-bit address adder between two requesters.
  - Port 0: branch/jump target path in the PC logic.
  - Port 1: load/store effective-address path.
- Computes base + sext(imm21) with round-robin arbitration and valid/ready handshakes.
- Result goes into a one-entry output register, tagged with its source.
- Sits between the decode stage and the PC/memory-address consumers when the processor is run multi-cycle.

Parameters:
- IMM_W, 21: immediate width; bit IMM_W-1 is the sign bit.
- DATA_W, 32: base, result and adder width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_base  input  DATA_W  requester 0 base (PC).
- req0_imm  input  IMM_W  requester 0 signed offset.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_base  input  DATA_W  requester 1 base (register value).
- req1_imm  input  IMM_W  requester 1 signed offset.
- res_valid  output  1  res_addr/res_src hold a valid result.
- res_ready  input  1  consumer takes result this cycle.
- res_addr  output  DATA_W  registered base + sext(imm), modulo 2^DATA_W.
- res_src  output  1  0 = result from requester 0, 1 = from requester 1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_addr=0, res_src=0.
  - Priority pointer last_grant=1, so requester 0 wins the first contention.
  - Any held result is discarded; no ready is asserted during the reset cycle.
- Slot free when res_valid==0, or when res_valid==1 and res_ready==1 in the same cycle (drain and refill, full throughput).
- Grant (combinational, only when slot free):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqN_ready=1 only for the granted requester. Both readies are never 1 together. Both are 0 when the slot is not free.
- A transfer occurs when reqN_valid && reqN_ready. At the next edge:
  - res_addr <= reqN_base + {{(DATA_W-IMM_W){reqN_imm[IMM_W-1]}}, reqN_imm}.
  - res_src <= N; res_valid <= 1; last_grant <= N.
- Latency: exactly 1 cycle from accept to res_valid.
- Drain with no new grant: res_valid <= 0. res_addr/res_src keep their last values.
- Held result (res_valid=1, res_ready=0):
  - res_addr, res_src, res_valid are stable.
  - Both readies stay 0, so requesters stall and must hold their operands.
- Adder wraps silently: no carry or overflow output.
- last_grant changes only on a transfer, so an idle cycle does not disturb fairness.
- Requester valid/operands may change only after the handshake. Dropping valid before ready is tolerated: nothing is captured.
- Internal states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- Transitions:
  - EMPTY→FULL on transfer.
  - FULL→EMPTY on drain with no transfer.
  - FULL→FULL on drain+transfer, or on hold.
  - Any→EMPTY on rst.

Test Plan:
- Reset then single req0: base=0x00001000, imm=0x000010 → req0_ready=1 same cycle; next cycle res_valid=1, res_addr=0x00001010, res_src=0.
- Negative offset on req1: base=0x00001000, imm=0x1FFFFF (−1) → res_addr=0x00000FFF, res_src=1. Then imm=0x100000 with base=0 → res_addr=0xFFF00000.
- Wrap-around: base=0xFFFFFFF0, imm=0x000020 → res_addr=0x00000010, no other flag.
- Contention: both valid continuously, res_ready=1 → grants alternate 0,1,0,1 on consecutive cycles; one result per cycle; res_src sequence 0,1,0,1.
- Back-pressure: res_ready=0 for 3 cycles with result held → res_addr/res_src stable, both readies 0. res_ready=1 → result consumed and the waiting requester is accepted in the same cycle.
- Mid-operation reset: rst=1 while res_valid=1 and both requesting → next cycle res_valid=0, res_addr=0. First post-reset contention is granted to req0.
